// File: rtl/ram_arb_pkg.sv
// Shared types and bus widths for the two-master RAM port arbiter.
package ram_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic {ARB = 1'b0, HOLD = 1'b1} arb_state_t;

  typedef logic owner_t;
  localparam owner_t M0 = 1'b0;
  localparam owner_t M1 = 1'b1;

  function automatic owner_t other(input owner_t o);
    return ~o;
  endfunction
endpackage

// File: rtl/naive_bus.sv
// naive_bus: split read/write request-grant bus with a 1-cycle registered read return.
interface naive_bus;
  import ram_arb_pkg::*;

  logic              rd_req;
  logic              rd_gnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic              wr_gnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;

  modport master (output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
                  input  rd_gnt, rd_data, wr_gnt);
  modport slave  (input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
                  output rd_gnt, rd_data, wr_gnt);
endinterface

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin pick: under contention the master that did not win last time goes.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_win,
  output owner_t     win,
  output logic       any
);
  always_comb begin
    any = |req;
    case (req)
      2'b10:   win = M1;
      2'b11:   win = other(last_win);
      default: win = M0;
    endcase
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-ported RAM between two naive_bus masters with round-robin fairness,
// holding a losing-grant request until the RAM accepts it, and routing read data back.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  naive_bus.slave  m0,
  naive_bus.slave  m1,
  naive_bus.master s,
  output logic     stall_err
);
  arb_state_t        state_q;
  owner_t            owner_q, last_win_q, rd_who_q;
  owner_t            win, sel;
  logic              rd_pend_q, stall_err_q;
  logic [2:0]        hold_cnt_q, hold_cnt_d;
  logic [1:0]        req;
  logic              any, active, sel_rd, sel_wr, fw_rd, fw_wr, rd_hit, wr_hit, granted;
  logic              stall_hit;
  logic [ADDR_W-1:0] sel_rd_addr, sel_wr_addr;
  logic [DATA_W-1:0] sel_wr_data;
  logic [BE_W-1:0]   sel_wr_be;

  assign req = {m1.rd_req | m1.wr_req, m0.rd_req | m0.wr_req};

  rr_arb2 u_rr (
    .req      (req),
    .last_win (last_win_q),
    .win      (win),
    .any      (any)
  );

  // While holding, only the latched owner may reach the RAM.
  assign sel    = (state_q == HOLD) ? owner_q : win;
  assign active = rst_n & ((state_q == HOLD) ? req[sel] : any);

  always_comb begin
    sel_rd      = m0.rd_req;
    sel_wr      = m0.wr_req;
    sel_rd_addr = m0.rd_addr;
    sel_wr_addr = m0.wr_addr;
    sel_wr_data = m0.wr_data;
    sel_wr_be   = m0.wr_be;
    if (sel == M1) begin
      sel_rd      = m1.rd_req;
      sel_wr      = m1.wr_req;
      sel_rd_addr = m1.rd_addr;
      sel_wr_addr = m1.wr_addr;
      sel_wr_data = m1.wr_data;
      sel_wr_be   = m1.wr_be;
    end
  end

  // A simultaneous read is suppressed in favour of the write; the master retries it.
  assign fw_wr = active & sel_wr;
  assign fw_rd = active & sel_rd & ~sel_wr;

  assign s.wr_req  = fw_wr;
  assign s.rd_req  = fw_rd;
  assign s.wr_addr = sel_wr_addr;
  assign s.rd_addr = sel_rd_addr;
  assign s.wr_data = sel_wr_data;
  assign s.wr_be   = sel_wr_be;

  assign wr_hit  = fw_wr & s.wr_gnt;
  assign rd_hit  = fw_rd & s.rd_gnt;
  assign granted = wr_hit | rd_hit;

  assign m0.wr_gnt = wr_hit & (sel == M0);
  assign m0.rd_gnt = rd_hit & (sel == M0);
  assign m1.wr_gnt = wr_hit & (sel == M1);
  assign m1.rd_gnt = rd_hit & (sel == M1);

  assign m0.rd_data = (rd_pend_q && rd_who_q == M0) ? s.rd_data : '0;
  assign m1.rd_data = (rd_pend_q && rd_who_q == M1) ? s.rd_data : '0;

  assign hold_cnt_d = (hold_cnt_q == 3'd7) ? 3'd7 : hold_cnt_q + 3'd1;
  assign stall_hit  = (state_q == HOLD) && (HOLD_MAX != 0) && ({29'd0, hold_cnt_d} >= HOLD_MAX);
  assign stall_err  = stall_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      owner_q     <= M0;
      last_win_q  <= M1;
      rd_pend_q   <= 1'b0;
      rd_who_q    <= M0;
      hold_cnt_q  <= 3'd0;
      stall_err_q <= 1'b0;
    end else begin
      rd_pend_q <= rd_hit;
      if (rd_hit) rd_who_q <= sel;
      if (stall_hit) stall_err_q <= 1'b1;
      case (state_q)
        ARB: begin
          hold_cnt_q <= 3'd0;
          if (any) begin
            if (granted) begin
              last_win_q <= win;
            end else begin
              state_q <= HOLD;
              owner_q <= win;
            end
          end
        end
        HOLD: begin
          hold_cnt_q <= hold_cnt_d;
          if (!req[owner_q]) begin
            state_q <= ARB;
          end else if (granted) begin
            last_win_q <= owner_q;
            state_q    <= ARB;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end
endmodule
